// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, default widths and
// register offsets used by both the transmit and receive sides.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int UART_DATA_BITS     = 8;
  localparam int UART_CLK_DIV_WIDTH = 16;

  localparam logic [7:0] UART_REG_DATA    = 8'h00;
  localparam logic [7:0] UART_REG_STATUS  = 8'h04;
  localparam logic [7:0] UART_REG_CLK_DIV = 8'h08;

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-timing down-counter; load wins over enable, zero flags the bit boundary.
module uart_baud_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic [WIDTH-1:0] count,
  output logic             zero
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable) begin
      count <= count - {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: valid/ready byte intake, LSB-first serialiser,
// bit timing from a divisor captured when the byte is accepted.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS     = UART_DATA_BITS,
  parameter int CLK_DIV_WIDTH = UART_CLK_DIV_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [CLK_DIV_WIDTH-1:0] clk_div,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_BITS-1:0]     in_data,
  output logic                     tx,
  output logic                     busy
);

  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IDX_W-1:0]         LAST_IDX = IDX_W'(DATA_BITS - 1);
  localparam logic [CLK_DIV_WIDTH-1:0] DIV_ONE  = {{(CLK_DIV_WIDTH-1){1'b0}}, 1'b1};

  tx_state_t                state, state_n;
  logic [DATA_BITS-1:0]     shift, shift_n;
  logic [IDX_W-1:0]         bit_idx, bit_idx_n;
  logic [CLK_DIV_WIDTH-1:0] div_q, div_q_n;
  logic                     tx_n;

  logic [CLK_DIV_WIDTH-1:0] div_eff;
  logic [CLK_DIV_WIDTH-1:0] tx_clks;
  logic                     tx_clks_zero;
  logic                     accept;
  logic                     active;
  logic                     boundary;
  logic                     cnt_load;
  logic [CLK_DIV_WIDTH-1:0] cnt_load_value;

  assign in_ready = (state == IDLE) && !reset;
  assign busy     = (state != IDLE);
  assign accept   = in_valid && in_ready;
  assign active   = (state != IDLE);
  assign boundary = active && tx_clks_zero;
  assign div_eff  = (clk_div == '0) ? DIV_ONE : clk_div;

  // A fresh frame loads the new divisor; a bit boundary reloads the captured one.
  assign cnt_load       = accept || boundary;
  assign cnt_load_value = accept ? (div_eff - DIV_ONE) : (div_q - DIV_ONE);

  uart_baud_counter #(
    .WIDTH (CLK_DIV_WIDTH)
  ) u_tx_clks (
    .clk        (clk),
    .reset      (reset),
    .load       (cnt_load),
    .load_value (cnt_load_value),
    .enable     (active),
    .count      (tx_clks),
    .zero       (tx_clks_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      tx      <= 1'b1;
      shift   <= '0;
      bit_idx <= '0;
      div_q   <= DIV_ONE;
    end else begin
      state   <= state_n;
      tx      <= tx_n;
      shift   <= shift_n;
      bit_idx <= bit_idx_n;
      div_q   <= div_q_n;
    end
  end

  always_comb begin
    state_n   = state;
    tx_n      = tx;
    shift_n   = shift;
    bit_idx_n = bit_idx;
    div_q_n   = div_q;
    case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (accept) begin
          shift_n = in_data;
          div_q_n = div_eff;
          state_n = START;
          tx_n    = 1'b0;
        end
      end
      START: begin
        if (boundary) begin
          state_n   = DATA;
          tx_n      = shift[0];
          bit_idx_n = '0;
        end
      end
      DATA: begin
        if (boundary) begin
          if (bit_idx == LAST_IDX) begin
            state_n = STOP;
            tx_n    = 1'b1;
          end else begin
            bit_idx_n = bit_idx + 1'b1;
            shift_n   = shift >> 1;
            tx_n      = shift[1];
          end
        end
      end
      STOP: begin
        tx_n = 1'b1;
        if (boundary) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end

endmodule
